// File: rtl/pipe_stage_elastic_pkg.sv
`default_nettype none
// ============================================================================
// pipe_pkg : shared types and default widths for elastic pipeline stages
// Revision : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_TAG_W  = 8;

    typedef enum logic [1:0] {
        PS_EMPTY = 2'd0,
        PS_ONE   = 2'd1,
        PS_FULL  = 2'd2
    } pipe_state_t;

endpackage
`default_nettype wire

// File: rtl/pipe_stage_elastic_sat_counter.sv
`default_nettype none
// ============================================================================
// sat_counter : up-counter that sticks at its all-ones value
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/pipe_stage_elastic.sv
`default_nettype none
// ============================================================================
// pipe_stage_elastic : valid/ready pipeline register with optional skid entry,
//                      synchronous flush and stall/bubble profiling counters
// Revision           : 1.0 - initial release
// ============================================================================
module pipe_stage_elastic
    import pipe_pkg::*;
#(
    parameter int DATA_W  = DEFAULT_DATA_W,
    parameter int TAG_W   = DEFAULT_TAG_W,
    parameter int SKID_EN = 1,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [TAG_W-1:0]  out_tag,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    localparam int ENTRY_W = TAG_W + DATA_W;

    pipe_state_t        state;
    pipe_state_t        state_next;
    logic [ENTRY_W-1:0] head;
    logic [ENTRY_W-1:0] skid;
    logic               head_load_in;
    logic               head_load_skid;
    logic               skid_load;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= PS_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Flush wins over any accept, so in-flight input is simply never loaded.
    always_comb begin
        state_next     = state;
        head_load_in   = 1'b0;
        head_load_skid = 1'b0;
        skid_load      = 1'b0;
        if (flush) begin
            state_next = PS_EMPTY;
        end else begin
            case (state)
                PS_EMPTY: begin
                    if (in_valid) begin
                        state_next   = PS_ONE;
                        head_load_in = 1'b1;
                    end
                end
                PS_ONE: begin
                    if (out_ready) begin
                        if (in_valid) begin
                            head_load_in = 1'b1;
                        end else begin
                            state_next = PS_EMPTY;
                        end
                    end else if (in_valid && (SKID_EN != 0)) begin
                        state_next = PS_FULL;
                        skid_load  = 1'b1;
                    end
                end
                PS_FULL: begin
                    if (out_ready) begin
                        state_next     = PS_ONE;
                        head_load_skid = 1'b1;
                    end
                end
                default: state_next = PS_EMPTY;
            endcase
        end
    end

    always_comb begin
        out_valid = (state != PS_EMPTY);
        if (SKID_EN != 0) begin
            in_ready = (state != PS_FULL);
        end else begin
            in_ready = (state == PS_EMPTY) || out_ready;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            head <= '0;
        end else if (head_load_in) begin
            head <= {in_tag, in_data};
        end else if (head_load_skid) begin
            head <= skid;
        end
    end

    generate
        if (SKID_EN != 0) begin : g_skid
            always_ff @(posedge clk) begin
                if (reset || flush) begin
                    skid <= '0;
                end else if (skid_load) begin
                    skid <= {in_tag, in_data};
                end
            end
        end else begin : g_no_skid
            assign skid = '0;
        end
    endgenerate

    assign out_data = head[DATA_W-1:0];
    assign out_tag  = head[ENTRY_W-1:DATA_W];

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (out_valid & ~out_ready),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (~out_valid & out_ready),
        .count (bubble_cnt)
    );

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_elastic.sv
`default_nettype none
// ============================================================================
// tb_pipe_stage_elastic : directed bench for skid, no-skid and 4-bit-counter stages
// Revision              : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_elastic;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // main stage: skid enabled, 16-bit counters
    logic        m_flush, m_in_valid, m_in_ready, m_out_valid, m_out_ready;
    logic [31:0] m_in_data, m_out_data;
    logic [7:0]  m_in_tag, m_out_tag;
    logic [15:0] m_stall, m_bubble;

    // classic enable stage: no skid
    logic        z_in_valid, z_in_ready, z_out_valid, z_out_ready;
    logic [31:0] z_in_data, z_out_data;
    logic [7:0]  z_out_tag;
    logic [15:0] z_stall, z_bubble;

    // narrow-counter stage
    logic        c_in_ready, c_out_valid, c_out_ready;
    logic [31:0] c_out_data;
    logic [7:0]  c_out_tag;
    logic [3:0]  c_stall, c_bubble;

    pipe_stage_elastic #(.DATA_W(32), .TAG_W(8), .SKID_EN(1), .CNT_W(16)) u_main (
        .clk(clk), .reset(reset), .flush(m_flush),
        .in_valid(m_in_valid), .in_ready(m_in_ready), .in_data(m_in_data), .in_tag(m_in_tag),
        .out_valid(m_out_valid), .out_ready(m_out_ready), .out_data(m_out_data), .out_tag(m_out_tag),
        .stall_cnt(m_stall), .bubble_cnt(m_bubble)
    );

    pipe_stage_elastic #(.DATA_W(32), .TAG_W(8), .SKID_EN(0), .CNT_W(16)) u_noskid (
        .clk(clk), .reset(reset), .flush(1'b0),
        .in_valid(z_in_valid), .in_ready(z_in_ready), .in_data(z_in_data), .in_tag(8'h00),
        .out_valid(z_out_valid), .out_ready(z_out_ready), .out_data(z_out_data), .out_tag(z_out_tag),
        .stall_cnt(z_stall), .bubble_cnt(z_bubble)
    );

    pipe_stage_elastic #(.DATA_W(32), .TAG_W(8), .SKID_EN(1), .CNT_W(4)) u_cnt4 (
        .clk(clk), .reset(reset), .flush(1'b0),
        .in_valid(1'b0), .in_ready(c_in_ready), .in_data(32'h0), .in_tag(8'h00),
        .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data), .out_tag(c_out_tag),
        .stall_cnt(c_stall), .bubble_cnt(c_bubble)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        m_flush = 1'b0; m_in_valid = 1'b1; m_in_data = 32'h77; m_in_tag = 8'h77; m_out_ready = 1'b0;
        z_in_valid = 1'b0; z_in_data = 32'h0; z_out_ready = 1'b0;
        c_out_ready = 1'b0;

        // reset held two edges with input offered
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(m_out_valid), 32'd0);
        chk("rst_out_data", m_out_data, 32'd0);
        chk("rst_out_tag", 32'(m_out_tag), 32'd0);
        chk("rst_stall", 32'(m_stall), 32'd0);
        chk("rst_bubble", 32'(m_bubble), 32'd0);
        reset = 1'b0;
        m_in_valid = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 32'(m_in_ready), 32'd1);
        chk("rst_z_in_ready", 32'(z_in_ready), 32'd1);
        chk("rst_c_in_ready", 32'(c_in_ready), 32'd1);
        cyc();

        // streaming 1..8 with no backpressure
        for (int k = 1; k <= 9; k++) begin
            m_in_valid  = (k <= 8);
            m_in_data   = 32'(k);
            m_in_tag    = 8'(k) ^ 8'h5A;
            m_out_ready = 1'b1;
            @(negedge clk);
            if (k >= 2) begin
                chk("strm_valid", 32'(m_out_valid), 32'd1);
                chk("strm_data", m_out_data, 32'(k - 1));
                chk("strm_tag", 32'(m_out_tag), 32'(8'(k - 1) ^ 8'h5A));
            end else begin
                chk("strm_first_empty", 32'(m_out_valid), 32'd0);
            end
            cyc();
        end
        m_in_valid = 1'b0;
        @(negedge clk);
        chk("strm_drained", 32'(m_out_valid), 32'd0);
        chk("strm_stall", 32'(m_stall), 32'd0);
        cyc();

        // backpressure fills head then skid
        m_in_valid = 1'b1; m_in_data = 32'hA; m_in_tag = 8'hA0; m_out_ready = 1'b0;
        @(negedge clk);
        chk("bp_ready_a", 32'(m_in_ready), 32'd1);
        cyc();
        m_in_data = 32'hB; m_in_tag = 8'hB0;
        @(negedge clk);
        chk("bp_head_a", m_out_data, 32'hA);
        chk("bp_ready_b", 32'(m_in_ready), 32'd1);
        cyc();
        m_in_data = 32'hC; m_in_tag = 8'hC0;
        @(negedge clk);
        chk("bp_full_ready", 32'(m_in_ready), 32'd0);
        chk("bp_hold_a", m_out_data, 32'hA);
        chk("bp_stall1", 32'(m_stall), 32'd1);
        cyc();
        @(negedge clk);
        chk("bp_full_ready2", 32'(m_in_ready), 32'd0);
        chk("bp_hold_a2", m_out_data, 32'hA);
        chk("bp_stall2", 32'(m_stall), 32'd2);
        cyc();
        m_out_ready = 1'b1;
        @(negedge clk);
        chk("bp_out_a_valid", 32'(m_out_valid), 32'd1);
        chk("bp_out_a", m_out_data, 32'hA);
        chk("bp_out_a_tag", 32'(m_out_tag), 32'hA0);
        chk("bp_stall3", 32'(m_stall), 32'd3);
        cyc();
        @(negedge clk);
        chk("bp_out_b", m_out_data, 32'hB);
        chk("bp_out_b_tag", 32'(m_out_tag), 32'hB0);
        chk("bp_ready_c", 32'(m_in_ready), 32'd1);
        cyc();
        m_in_valid = 1'b0;
        @(negedge clk);
        chk("bp_out_c_valid", 32'(m_out_valid), 32'd1);
        chk("bp_out_c", m_out_data, 32'hC);
        cyc();
        @(negedge clk);
        chk("bp_empty", 32'(m_out_valid), 32'd0);
        chk("bp_stall_total", 32'(m_stall), 32'd3);
        cyc();

        // flush while FULL with input offered
        m_in_valid = 1'b1; m_in_data = 32'h1; m_in_tag = 8'h11; m_out_ready = 1'b0;
        cyc();
        m_in_data = 32'h2; m_in_tag = 8'h22;
        cyc();
        m_flush = 1'b1; m_in_data = 32'hD; m_in_tag = 8'hDD;
        @(negedge clk);
        chk("fl_full_ready", 32'(m_in_ready), 32'd0);
        cyc();
        m_flush = 1'b0; m_in_valid = 1'b0; m_out_ready = 1'b1;
        @(negedge clk);
        chk("fl_out_valid", 32'(m_out_valid), 32'd0);
        chk("fl_out_data", m_out_data, 32'd0);
        chk("fl_out_tag", 32'(m_out_tag), 32'd0);
        chk("fl_in_ready", 32'(m_in_ready), 32'd1);
        cyc();
        @(negedge clk);
        chk("fl_no_d", 32'(m_out_valid), 32'd0);
        chk("fl_stall", 32'(m_stall), 32'd5);
        cyc();

        // no-skid stage: combinational ready follows out_ready
        z_in_valid = 1'b1; z_in_data = 32'h11; z_out_ready = 1'b0;
        @(negedge clk);
        chk("ns_ready_empty", 32'(z_in_ready), 32'd1);
        cyc();
        z_in_data = 32'h22;
        @(negedge clk);
        chk("ns_head", z_out_data, 32'h11);
        chk("ns_ready_blocked", 32'(z_in_ready), 32'd0);
        z_out_ready = 1'b1;
        #1;
        chk("ns_ready_comb", 32'(z_in_ready), 32'd1);
        cyc();
        z_in_valid = 1'b0;
        @(negedge clk);
        chk("ns_next_valid", 32'(z_out_valid), 32'd1);
        chk("ns_next_data", z_out_data, 32'h22);
        cyc();
        @(negedge clk);
        chk("ns_drained", 32'(z_out_valid), 32'd0);
        cyc();

        // 4-bit bubble counter saturation
        chk("sat_start", 32'(c_bubble), 32'd0);
        c_out_ready = 1'b1;
        repeat (14) @(posedge clk);
        @(negedge clk);
        chk("sat_14", 32'(c_bubble), 32'd14);
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("sat_15", 32'(c_bubble), 32'd15);
        chk("sat_stall", 32'(c_stall), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
